// File: rtl/set_job_dispatcher.sv
// set_job_dispatcher: queues SET circle-candidate jobs, issues them one at a time,
// and returns each indexed count (or a timeout marker) on a valid/ready port.
module set_job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int IDX_W   = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [23:0]      job_central,
    input  logic [11:0]      job_radius,
    input  logic [1:0]       job_mode,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_index,
    output logic [7:0]       res_candidate,
    output logic             res_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t state, state_nx;

    logic [37:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [TW-1:0] tcnt;
    logic          empty, full, push, pop, timeout, done;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign job_ready = !full;
    assign push      = job_valid && job_ready;
    assign pop       = (state == IDLE) && !empty && !set_busy && !res_valid;
    assign timeout   = tcnt == TW'(TIMEOUT - 1);
    assign done      = (state == WAIT) && (set_valid || timeout);
    assign set_en    = state == ISSUE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pop ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = done ? HOLD : WAIT;
            default: state_nx = res_ready ? IDLE : HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {job_central, job_radius, job_mode};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tcnt          <= '0;
            set_central   <= '0;
            set_radius    <= '0;
            set_mode      <= '0;
            res_valid     <= 1'b0;
            res_index     <= '0;
            res_candidate <= '0;
            res_err       <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                {set_central, set_radius, set_mode} <= mem[rd_ptr[AW-1:0]];
            end
            tcnt <= (state == ISSUE) ? '0 : (state == WAIT) ? tcnt + TW'(1) : tcnt;
            // A result arriving on the timeout cycle takes precedence over the abort.
            if (done) begin
                res_valid     <= 1'b1;
                res_candidate <= set_valid ? set_candidate : 8'hFF;
                res_err       <= !set_valid;
            end
            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
                res_index <= res_index + IDX_W'(1);
            end
        end
    end
endmodule
